matrix_vec_loader: RTL and testbench
====================================

// Module: matrix_vec_loader
// PURPOSE
//  Upstream feeder for matrix_vec_mul. Accepts a serial stream of binary elements
//  (valid/ready), assembles one n x n matrix M and one n-vector v, then presents
//  them as flat, stable buses with out_valid until the consumer takes them.
//  Replaces per-element stimulus toggling with a framed, checkable load path.
// PARAMETERS
//  N  3  matrix dimension (N x N matrix, N-element vector); N >= 1
//  W  1  bits per element
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      in_data/in_last valid this cycle
//  in_ready   out  1      loader accepts an element this cycle
//  in_data    in   W      element: M row-major (M[0][0]..M[N-1][N-1]), then v[0]..v[N-1]
//  in_last    in   1      marks final element of a frame (beat index N*N+N-1)
//  out_valid  out  1      M_flat/v_flat hold a complete frame
//  out_ready  in   1      consumer takes the frame
//  M_flat     out  N*N*W  M[r][c] at M_flat[(r*N+c)*W +: W]
//  v_flat     out  N*W    v[i] at v_flat[i*W +: W]
//  frame_err  out  1      one-cycle pulse: framing error, frame discarded
// BEHAVIOUR
//  Reset (rst_n low, async): state=LOAD, idx=0, M_flat=0, v_flat=0, out_valid=0,
//   frame_err=0; in_ready=1 (in_ready = state==LOAD, combinational).
//  Beat accepted when in_valid && in_ready at a rising edge; idx counts 0..N*N+N-1.
//   idx < N*N  : write in_data into M element idx (r=idx/N, c=idx%N).
//   idx >= N*N : write in_data into v[idx-N*N].
//  States: LOAD  - accept beats; out_valid=0.
//          HOLD  - in_ready=0; out_valid=1; M_flat/v_flat frozen.
//  LOAD->HOLD: accepted beat with idx==N*N+N-1 and in_last=1; out_valid rises
//   on that same edge (0 cycles after final beat); idx->0.
//  HOLD->LOAD: out_valid && out_ready at an edge; out_valid falls, in_ready
//   high in the next cycle. No bypass: one idle cycle min between frames on input.
//  Framing errors (state stays LOAD, idx->0, frame_err=1 for one cycle, no out_valid):
//   - in_last=1 on accepted beat with idx < N*N+N-1 (short frame);
//   - in_last=0 on accepted beat with idx == N*N+N-1 (long frame).
//   The errored beat's data is still written; partially written M/v are don't-care
//   until the next good frame completes (out_valid low guarantees consumer ignores).
//  in_valid=0 in LOAD: idx and registers hold (gaps allowed anywhere in a frame).
//  in_valid/in_data ignored in HOLD (in_ready=0); no element is lost or counted.
//  M_flat/v_flat retain last values after handoff until overwritten by next frame.
//  Async reset mid-frame or mid-HOLD: immediate return to reset values; partial
//   frame discarded; first beat after reset release is idx 0.
//  idx counter width: $clog2(N*N+N) bits; never exceeds N*N+N-1.
// TESTING (N=3, W=1 unless stated)
//  1 Reset: rst_n=0 mid-sim -> out_valid=0, M_flat=9'h0, v_flat=3'h0, in_ready=1 at once.
//  2 Good frame, back-to-back: 12 beats data 1,0,1,0,1,0,1,0,1, 1,1,0 with in_last on
//    12th -> out_valid=1 same edge, M_flat=9'b101010101, v_flat=3'b011; out_ready=1
//    one cycle later -> out_valid=0, in_ready=1 next cycle.
//  3 Backpressure: hold out_ready=0 for 20 cycles while in_valid=1, in_data toggling
//    -> in_ready=0, M_flat/v_flat unchanged; then out_ready=1 -> handoff, next frame
//    loads from idx 0.
//  4 Short frame: in_last on beat 5 -> frame_err one cycle, out_valid stays 0;
//    following good frame of all-ones -> M_flat=9'h1FF, v_flat=3'h7.
//  5 Long frame: no in_last on beat 12 -> frame_err, no out_valid; next good frame OK.
//  6 Gaps + mid-frame reset: random in_valid gaps produce correct frame; rst_n pulse
//    after beat 7 -> next 12 beats form a fresh correct frame; repeat for N=2, W=2.

Source files
------------

// File: rtl/matrix_vec_loader.sv
// Serial-to-parallel frame loader: assembles an N x N matrix and an N-vector
// from a valid/ready element stream and holds them on flat buses until taken.
module matrix_vec_loader #(
  parameter int N = 3,
  parameter int W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*N*W-1:0] M_flat,
  output logic [N*W-1:0]   v_flat,
  output logic             frame_err
);

  localparam int MN    = N * N;
  localparam int BEATS = MN + N;
  localparam int IDX_W = $clog2(BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             err_nxt;
  logic             beat_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      idx       <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      frame_err <= err_nxt;
    end
  end

  // Any in_last/position disagreement drops the frame and rewinds to beat 0.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    err_nxt   = 1'b0;
    in_ready  = (state == LOAD);
    out_valid = (state == HOLD);
    beat_acc  = in_valid && (state == LOAD);
    case (state)
      LOAD: begin
        if (beat_acc) begin
          if (idx == LAST_IDX) begin
            idx_nxt = '0;
            if (in_last) begin
              state_nxt = HOLD;
            end else begin
              err_nxt = 1'b1;
            end
          end else if (in_last) begin
            idx_nxt = '0;
            err_nxt = 1'b1;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = LOAD;
        end
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

  // Element storage: beat idx lands in M (row-major) first, then in v.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      M_flat <= '0;
      v_flat <= '0;
    end else if (beat_acc) begin
      for (int e = 0; e < MN; e++) begin
        if (idx == IDX_W'(e)) begin
          M_flat[e*W +: W] <= in_data;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (idx == IDX_W'(MN + i)) begin
          v_flat[i*W +: W] <= in_data;
        end
      end
    end
  end

  a_idx_range: assert property (@(posedge clk) disable iff (!rst_n) idx <= LAST_IDX);
  a_err_no_valid: assert property (@(posedge clk) disable iff (!rst_n) frame_err |-> !out_valid);

endmodule

// File: tb/tb_matrix_vec_loader.sv
// Directed bench for matrix_vec_loader: table-driven cycle vectors on an N=3/W=1
// instance plus hand sequences for resets, gaps and an N=2/W=2 instance.
module tb_matrix_vec_loader;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic       rst_n3, iv3, ir3, il3, ov3, or3, fe3;
  logic [0:0] d3;
  logic [8:0] m3;
  logic [2:0] v3;

  logic       rst_n2, iv2, ir2, il2, ov2, or2, fe2;
  logic [1:0] d2;
  logic [7:0] m2;
  logic [3:0] v2;

  matrix_vec_loader #(.N(3), .W(1)) dut3 (
    .clk(clk), .rst_n(rst_n3), .in_valid(iv3), .in_ready(ir3), .in_data(d3),
    .in_last(il3), .out_valid(ov3), .out_ready(or3), .M_flat(m3), .v_flat(v3),
    .frame_err(fe3)
  );

  matrix_vec_loader #(.N(2), .W(2)) dut2 (
    .clk(clk), .rst_n(rst_n2), .in_valid(iv2), .in_ready(ir2), .in_data(d2),
    .in_last(il2), .out_valid(ov2), .out_ready(or2), .M_flat(m2), .v_flat(v2),
    .frame_err(fe2)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       iv;
    logic       d;
    logic       il;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic       e_fe;
    logic       chk;
    logic [8:0] e_m;
    logic [2:0] e_v;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic iv, input logic d, input logic il, input logic ordy,
                              input logic e_ir, input logic e_ov, input logic e_fe,
                              input logic chk, input logic [8:0] e_m, input logic [2:0] e_v);
    vec_t r;
    r.iv = iv; r.d = d; r.il = il; r.ordy = ordy;
    r.e_ir = e_ir; r.e_ov = e_ov; r.e_fe = e_fe;
    r.chk = chk; r.e_m = e_m; r.e_v = e_v;
    tbl.push_back(r);
  endfunction

  // beats[k] is the element sent on beat k; expected buses are given by hand.
  function automatic void add_good(input logic [11:0] beats, input logic [8:0] e_m,
                                   input logic [2:0] e_v);
    for (int k = 0; k < 12; k++) begin
      add(1'b1, beats[k], (k == 11), 1'b0, (k != 11), (k == 11), 1'b0, (k == 11), e_m, e_v);
    end
  endfunction

  task automatic send3(input logic d, input logic last, input int max_gap);
    int g;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    iv3 = 1'b0;
    repeat (g) begin
      @(posedge clk); #1;
    end
    iv3 = 1'b1; d3 = d; il3 = last;
    @(posedge clk); #1;
    iv3 = 1'b0; il3 = 1'b0;
    check("n3.beat_no_err", fe3, 1'b0);
  endtask

  task automatic frame3(input logic [11:0] beats, input int max_gap);
    for (int k = 0; k < 12; k++) send3(beats[k], (k == 11), max_gap);
  endtask

  task automatic send2(input logic [1:0] d, input logic last, input int max_gap);
    int g;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    iv2 = 1'b0;
    repeat (g) begin
      @(posedge clk); #1;
    end
    iv2 = 1'b1; d2 = d; il2 = last;
    @(posedge clk); #1;
    iv2 = 1'b0; il2 = 1'b0;
    check("n2.beat_no_err", fe2, 1'b0);
  endtask

  task automatic frame2(input logic [11:0] beats, input int max_gap);
    for (int k = 0; k < 6; k++) send2(beats[2*k +: 2], (k == 5), max_gap);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n3 = 1'b0; iv3 = 1'b0; d3 = '0; il3 = 1'b0; or3 = 1'b0;
    rst_n2 = 1'b0; iv2 = 1'b0; d2 = '0; il2 = 1'b0; or2 = 1'b0;

    // Good frame 1,0,1,0,1,0,1,0,1 | 1,1,0 then handoff.
    add_good(12'h755, 9'h155, 3'h3);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'h155, 3'h3);
    // Backpressure: 20 cycles of toggling input while held.
    add_good(12'h9C3, 9'h1C3, 3'h4);
    for (int k = 0; k < 20; k++) begin
      add(1'b1, 1'(k % 2), 1'(k % 3 == 0), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'h1C3, 3'h4);
    end
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'h1C3, 3'h4);
    add_good(12'h23E, 9'h03E, 3'h1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'h03E, 3'h1);
    // Short frame: in_last on beat 5.
    for (int k = 0; k < 5; k++) begin
      add(1'b1, 1'b1, (k == 4), 1'b0, 1'b1, 1'b0, (k == 4), 1'b0, 9'h0, 3'h0);
    end
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 3'h0);
    add_good(12'hFFF, 9'h1FF, 3'h7);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'h1FF, 3'h7);
    // Long frame: no in_last on beat 12.
    for (int k = 0; k < 12; k++) begin
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (k == 11), 1'b0, 9'h0, 3'h0);
    end
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 3'h0);
    add_good(12'h5A3, 9'h1A3, 3'h2);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'h1A3, 3'h2);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'h1A3, 3'h2);

    repeat (2) @(posedge clk);
    #2;
    check("rst.ov3", ov3, 1'b0);
    check("rst.ir3", ir3, 1'b1);
    check("rst.m3", m3, 9'h0);
    check("rst.v3", v3, 3'h0);
    check("rst.fe3", fe3, 1'b0);
    check("rst.ov2", ov2, 1'b0);
    check("rst.ir2", ir2, 1'b1);
    check("rst.m2", m2, 8'h0);
    check("rst.v2", v2, 4'h0);
    rst_n3 = 1'b1;
    rst_n2 = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      iv3 = tbl[i].iv; d3 = tbl[i].d; il3 = tbl[i].il; or3 = tbl[i].ordy;
      @(posedge clk); #1;
      check($sformatf("vec%0d.in_ready", i), ir3, tbl[i].e_ir);
      check($sformatf("vec%0d.out_valid", i), ov3, tbl[i].e_ov);
      check($sformatf("vec%0d.frame_err", i), fe3, tbl[i].e_fe);
      if (tbl[i].chk) begin
        check($sformatf("vec%0d.M_flat", i), m3, tbl[i].e_m);
        check($sformatf("vec%0d.v_flat", i), v3, tbl[i].e_v);
      end
    end
    iv3 = 1'b0; il3 = 1'b0; or3 = 1'b0;

    // Async reset while holding a frame takes effect without a clock edge.
    rst_n3 = 1'b0;
    #1;
    check("midhold_rst.ov3", ov3, 1'b0);
    check("midhold_rst.ir3", ir3, 1'b1);
    check("midhold_rst.m3", m3, 9'h0);
    check("midhold_rst.v3", v3, 3'h0);
    #2;
    rst_n3 = 1'b1;
    @(posedge clk); #1;

    // Gapped frame on N=3.
    frame3(12'hA5C, 3);
    check("gap3.ov", ov3, 1'b1);
    check("gap3.m", m3, 9'h05C);
    check("gap3.v", v3, 3'h5);
    or3 = 1'b1; @(posedge clk); #1; or3 = 1'b0;
    check("gap3.handoff", ov3, 1'b0);

    // Reset pulse after beat 7, then a fresh frame.
    for (int k = 0; k < 7; k++) send3(1'b1, 1'b0, 1);
    rst_n3 = 1'b0;
    #1;
    check("midframe_rst3.m", m3, 9'h0);
    #1;
    rst_n3 = 1'b1;
    frame3(12'h0F0, 2);
    check("after_rst3.ov", ov3, 1'b1);
    check("after_rst3.m", m3, 9'h0F0);
    check("after_rst3.v", v3, 3'h0);

    // N=2, W=2: elements m0..m3 = 3,1,2,0 and v = 2,3.
    frame2(12'hE27, 2);
    check("gap2.ov", ov2, 1'b1);
    check("gap2.ir", ir2, 1'b0);
    check("gap2.m", m2, 8'h27);
    check("gap2.v", v2, 4'hE);
    or2 = 1'b1; @(posedge clk); #1; or2 = 1'b0;
    check("gap2.handoff", ov2, 1'b0);
    check("gap2.retain_m", m2, 8'h27);

    for (int k = 0; k < 3; k++) send2(2'b11, 1'b0, 1);
    rst_n2 = 1'b0;
    #1;
    check("midframe_rst2.m", m2, 8'h0);
    check("midframe_rst2.v", v2, 4'h0);
    #1;
    rst_n2 = 1'b1;
    // Elements m = 1,2,3,3 and v = 0,1.
    frame2(12'h4F9, 2);
    check("after_rst2.ov", ov2, 1'b1);
    check("after_rst2.m", m2, 8'hF9);
    check("after_rst2.v", v2, 4'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
